// File: rtl/traffic_light_monitor.sv
// Passive checker for the intersection lamp outputs: lamp encoding, conflicts, phase order and phase timing.
// Lamps are registered into a sample register, then classified and tracked by the phase FSM one clock later.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_SYNC    | unlocked, waiting for a green entry to lock on
//   ST_NS_GO   | north-south green, east-west red
//   ST_NS_YEL  | north-south yellow, east-west red
//   ST_GAP_A   | all red between NS and EW
//   ST_EW_GO   | east-west green, north-south red
//   ST_EW_YEL  | east-west yellow, north-south red
//   ST_GAP_B   | all red between EW and NS
module traffic_light_monitor #(
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 50,
    parameter int YELLOW_LEN = 4,
    parameter int ALLRED_MAX = 2,
    parameter int LEN_W      = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ns_g_i,
    input  logic             ns_y_i,
    input  logic             ns_r_i,
    input  logic             ew_g_i,
    input  logic             ew_y_i,
    input  logic             ew_r_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic [2:0]       phase_o,
    output logic             err_evt_o,
    output logic             err_o,
    output logic [2:0]       err_code_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_NS_GO  = 3'd1,
        ST_NS_YEL = 3'd2,
        ST_GAP_A  = 3'd3,
        ST_EW_GO  = 3'd4,
        ST_EW_YEL = 3'd5,
        ST_GAP_B  = 3'd6
    } state_t;

    // PAT_NONE only exists between reset and the first valid sample.
    typedef enum logic [2:0] {
        PAT_NONE = 3'd0,
        PAT_NSG  = 3'd1,
        PAT_NSY  = 3'd2,
        PAT_RR   = 3'd3,
        PAT_EWG  = 3'd4,
        PAT_EWY  = 3'd5,
        PAT_BAD  = 3'd6
    } pat_t;

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_ENC      = 3'd1;
    localparam logic [2:0] E_CONFLICT = 3'd2;
    localparam logic [2:0] E_SEQ      = 3'd3;
    localparam logic [2:0] E_G_SHORT  = 3'd4;
    localparam logic [2:0] E_G_LONG   = 3'd5;
    localparam logic [2:0] E_Y_LEN    = 3'd6;
    localparam logic [2:0] E_GAP_LONG = 3'd7;

    localparam logic [LEN_W-1:0] G_MIN_L   = LEN_W'(GREEN_MIN);
    localparam logic [LEN_W-1:0] G_OVER_L  = LEN_W'(GREEN_MAX + 1);
    localparam logic [LEN_W-1:0] Y_LEN_L   = LEN_W'(YELLOW_LEN);
    localparam logic [LEN_W-1:0] Y_OVER_L  = LEN_W'(YELLOW_LEN + 1);
    localparam logic [LEN_W-1:0] GAP_OVER_L = LEN_W'(ALLRED_MAX + 1);

    logic [5:0]       s_q, s_d;
    logic             s_vld_q, s_vld_d;
    state_t           state_q, state_d;
    pat_t             pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_evt_q, err_evt_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic [2:0]       ns_l, ew_l;
    logic             enc_bad, conflict;
    pat_t             pat_cur;
    logic             pat_chg;
    logic [LEN_W-1:0] len_sat;
    logic             in_green, in_yellow, in_gap;
    logic             legal;
    state_t           nxt;
    logic [2:0]       code_new;

    assign ns_l     = s_q[5:3];
    assign ew_l     = s_q[2:0];
    assign enc_bad  = !$onehot(ns_l) || !$onehot(ew_l);
    assign conflict = !ns_l[0] && !ew_l[0];

    always_comb begin
        pat_cur = PAT_RR;
        if (enc_bad || conflict) begin
            pat_cur = PAT_BAD;
        end else if (ns_l[2]) begin
            pat_cur = PAT_NSG;
        end else if (ns_l[1]) begin
            pat_cur = PAT_NSY;
        end else if (ew_l[2]) begin
            pat_cur = PAT_EWG;
        end else if (ew_l[1]) begin
            pat_cur = PAT_EWY;
        end
    end

    assign pat_chg   = s_vld_q && (pat_cur != pat_q);
    assign len_sat   = (len_q == '1) ? len_q : len_q + LEN_W'(1);
    assign in_green  = (state_q == ST_NS_GO)  || (state_q == ST_EW_GO);
    assign in_yellow = (state_q == ST_NS_YEL) || (state_q == ST_EW_YEL);
    assign in_gap    = (state_q == ST_GAP_A)  || (state_q == ST_GAP_B);

    always_comb begin
        legal = 1'b0;
        nxt   = ST_SYNC;
        case (state_q)
            ST_NS_GO: begin
                if (pat_cur == PAT_NSY) begin legal = 1'b1; nxt = ST_NS_YEL; end
            end
            ST_NS_YEL: begin
                if (pat_cur == PAT_RR)  begin legal = 1'b1; nxt = ST_GAP_A; end
                if (pat_cur == PAT_EWG) begin legal = 1'b1; nxt = ST_EW_GO; end
            end
            ST_GAP_A: begin
                if (pat_cur == PAT_EWG) begin legal = 1'b1; nxt = ST_EW_GO; end
            end
            ST_EW_GO: begin
                if (pat_cur == PAT_EWY) begin legal = 1'b1; nxt = ST_EW_YEL; end
            end
            ST_EW_YEL: begin
                if (pat_cur == PAT_RR)  begin legal = 1'b1; nxt = ST_GAP_B; end
                if (pat_cur == PAT_NSG) begin legal = 1'b1; nxt = ST_NS_GO; end
            end
            ST_GAP_B: begin
                if (pat_cur == PAT_NSG) begin legal = 1'b1; nxt = ST_NS_GO; end
            end
            default: begin
                legal = 1'b0;
                nxt   = ST_SYNC;
            end
        endcase
    end

    // Priority chain: encoding, conflict, then sequence/timing only while locked.
    always_comb begin
        code_new = E_NONE;
        if (s_vld_q) begin
            if (enc_bad) begin
                code_new = E_ENC;
            end else if (conflict) begin
                code_new = E_CONFLICT;
            end else if (state_q != ST_SYNC) begin
                if (pat_chg) begin
                    if (!legal) begin
                        code_new = E_SEQ;
                    end else if (in_green && (len_q < G_MIN_L)) begin
                        code_new = E_G_SHORT;
                    end else if (in_yellow && (len_q != Y_LEN_L)) begin
                        code_new = E_Y_LEN;
                    end
                end else begin
                    if (in_green && (len_sat == G_OVER_L)) begin
                        code_new = E_G_LONG;
                    end else if (in_yellow && (len_sat == Y_OVER_L)) begin
                        code_new = E_Y_LEN;
                    end else if (in_gap && (len_sat == GAP_OVER_L)) begin
                        code_new = E_GAP_LONG;
                    end
                end
            end
        end
    end

    always_comb begin
        s_d         = {ns_g_i, ns_y_i, ns_r_i, ew_g_i, ew_y_i, ew_r_i};
        s_vld_d     = 1'b1;
        pat_d       = pat_q;
        len_d       = len_q;
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        err_evt_d   = (code_new != E_NONE);
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_cnt_d   = err_cnt_q;

        if (s_vld_q) begin
            pat_d = pat_cur;
            len_d = pat_chg ? LEN_W'(1) : len_sat;
        end

        if (code_new != E_NONE) begin
            state_d = ST_SYNC;
        end else if (pat_chg) begin
            if (state_q == ST_SYNC) begin
                // A green already present when sampling starts is not an entry.
                if (pat_q != PAT_NONE) begin
                    if (pat_cur == PAT_NSG) state_d = ST_NS_GO;
                    if (pat_cur == PAT_EWG) state_d = ST_EW_GO;
                end
            end else begin
                state_d = nxt;
                if (nxt == ST_NS_GO) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
        end

        if (clr_i) begin
            err_d      = 1'b0;
            err_code_d = E_NONE;
            err_cnt_d  = '0;
        end
        if (code_new != E_NONE) begin
            if (!err_d) err_code_d = code_new;
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_d == '1) ? err_cnt_d : err_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            s_vld_q     <= 1'b0;
            state_q     <= ST_SYNC;
            pat_q       <= PAT_NONE;
            len_q       <= '0;
            err_evt_q   <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= E_NONE;
            err_cnt_q   <= '0;
            cycle_cnt_q <= '0;
        end else begin
            s_q         <= s_d;
            s_vld_q     <= s_vld_d;
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            err_evt_q   <= err_evt_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign locked_o    = (state_q != ST_SYNC);
    assign phase_o     = state_q;
    assign err_evt_o   = err_evt_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign err_cnt_o   = err_cnt_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scoreboard bench for traffic_light_monitor with GREEN_MIN=4, GREEN_MAX=20, YELLOW_LEN=3, ALLRED_MAX=2.
// Each step pushes its expected outputs; they are popped and compared two clocks later.
module tb_traffic_light_monitor;

    localparam int CNT_W = 8;

    localparam logic [5:0] P_NSG  = 6'b100_001;
    localparam logic [5:0] P_NSY  = 6'b010_001;
    localparam logic [5:0] P_RR   = 6'b001_001;
    localparam logic [5:0] P_EWG  = 6'b001_100;
    localparam logic [5:0] P_EWY  = 6'b001_010;
    localparam logic [5:0] P_GG   = 6'b100_100;
    localparam logic [5:0] P_NSGY = 6'b110_001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
    logic             clr = 1'b0;
    logic             locked;
    logic [2:0]       phase;
    logic             err_evt;
    logic             err;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    traffic_light_monitor #(
        .GREEN_MIN (4),
        .GREEN_MAX (20),
        .YELLOW_LEN(3),
        .ALLRED_MAX(2),
        .LEN_W     (16),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ns_g_i     (ns_g),
        .ns_y_i     (ns_y),
        .ns_r_i     (ns_r),
        .ew_g_i     (ew_g),
        .ew_y_i     (ew_y),
        .ew_r_i     (ew_r),
        .clr_i      (clr),
        .locked_o   (locked),
        .phase_o    (phase),
        .err_evt_o  (err_evt),
        .err_o      (err),
        .err_code_o (err_code),
        .err_cnt_o  (err_cnt),
        .cycle_cnt_o(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [6:0] mask;   // 0 lock/phase, 1 evt, 2 err/code/cnt, 3 cycle count
        logic       lk;
        logic [2:0] ph;
        logic       evt;
        logic       er;
        logic [2:0] code;
        logic [7:0] ecnt;
        logic [7:0] ccnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t nxt;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step_no = 0;

    task automatic chk(input int tag, input string name, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL step%0d %s: observed %0h expected %0h", tag, name, obs, expv);
        end
    endtask

    task automatic exp_lk(input logic lk, input logic [2:0] ph);
        nxt.mask[0] = 1'b1; nxt.lk = lk; nxt.ph = ph;
    endtask

    task automatic exp_evt(input logic evt);
        nxt.mask[1] = 1'b1; nxt.evt = evt;
    endtask

    task automatic exp_err(input logic evt, input logic er, input logic [2:0] code, input logic [7:0] ecnt);
        nxt.mask[1] = 1'b1; nxt.evt = evt;
        nxt.mask[2] = 1'b1; nxt.er = er; nxt.code = code; nxt.ecnt = ecnt;
    endtask

    task automatic exp_cc(input logic [7:0] ccnt);
        nxt.mask[3] = 1'b1; nxt.ccnt = ccnt;
    endtask

    task automatic step_c(input logic [5:0] p, input logic c);
        exp_t e;
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = p;
        clr = c;
        step_no++;
        nxt.tag = step_no;
        sb_q.push_back(nxt);
        nxt = '{default: '0};
        @(posedge clk); #1;
        if (sb_q.size() == 2) begin
            e = sb_q.pop_front();
            if (e.mask[0]) begin
                chk(e.tag, "locked", 8'(locked), 8'(e.lk));
                chk(e.tag, "phase", 8'(phase), 8'(e.ph));
            end
            if (e.mask[1]) chk(e.tag, "err_evt", 8'(err_evt), 8'(e.evt));
            if (e.mask[2]) begin
                chk(e.tag, "err", 8'(err), 8'(e.er));
                chk(e.tag, "err_code", 8'(err_code), 8'(e.code));
                chk(e.tag, "err_cnt", err_cnt, e.ecnt);
            end
            if (e.mask[3]) chk(e.tag, "cycle_cnt", cycle_cnt, e.ccnt);
        end
    endtask

    task automatic step(input logic [5:0] p);
        step_c(p, 1'b0);
    endtask

    task automatic hold(input logic [5:0] p, input int n);
        for (int i = 0; i < n; i++) step(p);
    endtask

    task automatic check_zero(input int tag);
        chk(tag, "rst_locked", 8'(locked), 8'h0);
        chk(tag, "rst_phase", 8'(phase), 8'h0);
        chk(tag, "rst_evt", 8'(err_evt), 8'h0);
        chk(tag, "rst_err", 8'(err), 8'h0);
        chk(tag, "rst_code", 8'(err_code), 8'h0);
        chk(tag, "rst_ecnt", err_cnt, 8'h0);
        chk(tag, "rst_ccnt", cycle_cnt, 8'h0);
    endtask

    task automatic check_cleared(input int tag);
        chk(tag, "clr_err", 8'(err), 8'h0);
        chk(tag, "clr_code", 8'(err_code), 8'h0);
        chk(tag, "clr_ecnt", err_cnt, 8'h0);
    endtask

    initial begin
        nxt = '{default: '0};
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = P_RR;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero(0);
        rst = 1'b0;

        // legal loop, three full cycles
        step(P_RR);
        exp_lk(1'b0, 3'd0);
        step(P_RR);
        for (int k = 0; k < 3; k++) begin
            exp_lk(1'b1, 3'd1); exp_cc(8'(k));
            step(P_NSG); hold(P_NSG, 5);
            exp_lk(1'b1, 3'd2);
            step(P_NSY); hold(P_NSY, 2);
            exp_lk(1'b1, 3'd3);
            step(P_RR);
            exp_lk(1'b1, 3'd4);
            step(P_EWG); hold(P_EWG, 5);
            exp_lk(1'b1, 3'd5);
            step(P_EWY); hold(P_EWY, 2);
            exp_lk(1'b1, 3'd6);
            step(P_RR); step(P_RR);
        end
        exp_lk(1'b1, 3'd1); exp_cc(8'd3); exp_err(1'b0, 1'b0, 3'd0, 8'd0);
        step(P_NSG); hold(P_NSG, 5);

        // conflict while locked
        exp_lk(1'b0, 3'd0); exp_err(1'b1, 1'b1, 3'd2, 8'd1);
        step(P_GG);
        exp_evt(1'b0);
        step(P_RR);
        step_c(P_RR, 1'b1);
        check_cleared(step_no);

        // short yellow, then short green: first code held, count rises
        step(P_RR);
        exp_lk(1'b1, 3'd1);
        step(P_NSG); hold(P_NSG, 5);
        hold(P_NSY, 2);
        exp_lk(1'b0, 3'd0); exp_err(1'b1, 1'b1, 3'd6, 8'd1);
        step(P_RR);
        exp_lk(1'b1, 3'd1);
        step(P_NSG); hold(P_NSG, 2);
        exp_err(1'b1, 1'b1, 3'd6, 8'd2);
        step(P_NSY);
        step(P_RR);
        step_c(P_RR, 1'b1);

        // long green: one event on the 21st sample, no relock on the held green
        exp_lk(1'b1, 3'd1);
        step(P_NSG); hold(P_NSG, 18);
        exp_lk(1'b1, 3'd1); exp_evt(1'b0);
        step(P_NSG);
        exp_lk(1'b0, 3'd0); exp_err(1'b1, 1'b1, 3'd5, 8'd1);
        step(P_NSG);
        exp_evt(1'b0);
        step(P_NSG); hold(P_NSG, 2);
        exp_lk(1'b0, 3'd0); exp_err(1'b0, 1'b1, 3'd5, 8'd1);
        step(P_NSG);

        // illegal NS green -> EW green, with clear landing on the same clock
        step(P_RR);
        exp_lk(1'b1, 3'd1);
        step(P_NSG); hold(P_NSG, 5);
        exp_lk(1'b0, 3'd0); exp_err(1'b1, 1'b1, 3'd3, 8'd1);
        step(P_EWG);
        step_c(P_RR, 1'b1);
        step(P_RR);
        step_c(P_RR, 1'b1);
        check_cleared(step_no);
        exp_lk(1'b0, 3'd0); exp_err(1'b1, 1'b1, 3'd1, 8'd1);
        step(P_NSGY);
        step(P_RR);

        // reset during EW green, steady green afterwards does not lock
        exp_lk(1'b1, 3'd1);
        step(P_NSG); hold(P_NSG, 5);
        hold(P_NSY, 3);
        step(P_RR);
        exp_lk(1'b1, 3'd4);
        step(P_EWG); hold(P_EWG, 2);
        rst = 1'b1;
        step(P_EWG);
        check_zero(step_no);
        sb_q.delete();
        rst = 1'b0;
        exp_lk(1'b0, 3'd0);
        step(P_EWG);
        step(P_EWG);
        exp_lk(1'b0, 3'd0);
        step(P_EWG);
        step(P_RR);
        exp_lk(1'b1, 3'd1); exp_cc(8'd0); exp_err(1'b0, 1'b0, 3'd0, 8'd0);
        step(P_NSG);
        step(P_NSG);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
